apb4_ahb3lite_bridge: RTL and testbench

APB4-slave to AHB3-lite-master bridge: the reverse of the AHB3-lite to APB4 bridge. It turns each APB4 access into one AHB3-lite SINGLE transfer on a master port of the generated crossbar. This lets APB-side agents (debug/host controllers, test harnesses) reach ROM, RAM and peripherals in the system address map. Single clock domain; one outstanding transfer.

---
 rtl/apb4_ahb3lite_bridge_if.sv | 51 +++++
 rtl/apb4_ahb3lite_bridge.sv | 180 ++++++++++++++++++
 tb/tb_apb4_ahb3lite_bridge.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb4_ahb3lite_bridge_if.sv
// Bus bundles for the APB4-to-AHB3-lite bridge: an APB4 link and an AHB3-lite link,
// each with master/slave views.
interface apb4_if #(
    parameter int PADDR_SIZE = 16
);
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [PADDR_SIZE-1:0] PADDR;
    logic [31:0]           PWDATA;
    logic [3:0]            PSTRB;
    logic [2:0]            PPROT;
    logic [31:0]           PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

interface ahb3lite_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HWRITE;
    logic        HMASTLOCK;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HWDATA, HTRANS, HSIZE, HBURST, HPROT, HWRITE, HMASTLOCK,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWDATA, HTRANS, HSIZE, HBURST, HPROT, HWRITE, HMASTLOCK,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/apb4_ahb3lite_bridge.sv
// APB4 slave that replays each access as one AHB3-lite SINGLE transfer (one outstanding).
// Optional AHB stall timeout with bus drain: define APB4_AHB3_BRIDGE_TIMEOUT_EN.
module apb4_ahb3lite_bridge #(
    parameter logic [31:0] HADDR_BASE     = 32'h0000_0000,
    parameter int          PADDR_SIZE     = 16,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic       CLK,
    input  logic       RESETn,
    apb4_if.slave      apb,
    ahb3lite_if.master ahb
);
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_haddr;
    logic [31:0] r_hwdata;
    logic [31:0] r_prdata;
    logic [2:0]  r_hsize;
    logic [3:0]  r_hprot;
    logic        r_hwrite;
    logic        r_pslverr;

    logic [31:0] w_full_addr;
    logic [5:0]  w_dec;
    logic        w_strb_legal;
    logic        w_strb_empty;
    logic        w_accept;
    logic        w_timeout;
    logic        w_drain_busy;
    logic        w_drain_nonseq;
    logic        w_unused;

    // Returns {legal, HADDR[1:0], HSIZE} for a write strobe pattern.
    function automatic logic [5:0] f_strb_decode(input logic [3:0] strb);
        logic [5:0] dec;
        case (strb)
            4'b1111: dec = {1'b1, 2'b00, 3'b010};
            4'b0011: dec = {1'b1, 2'b00, 3'b001};
            4'b1100: dec = {1'b1, 2'b10, 3'b001};
            4'b0001: dec = {1'b1, 2'b00, 3'b000};
            4'b0010: dec = {1'b1, 2'b01, 3'b000};
            4'b0100: dec = {1'b1, 2'b10, 3'b000};
            4'b1000: dec = {1'b1, 2'b11, 3'b000};
            default: dec = {1'b0, 2'b00, 3'b000};
        endcase
        return dec;
    endfunction

    assign w_full_addr  = {HADDR_BASE[31:PADDR_SIZE], apb.PADDR};
    assign w_dec        = f_strb_decode(apb.PSTRB);
    assign w_strb_legal = w_dec[5];
    assign w_strb_empty = (apb.PSTRB == 4'b0000);
    assign w_accept     = (r_state == S_IDLE) && apb.PSEL && !w_drain_busy;
    assign w_unused     = ^{apb.PENABLE, apb.PPROT[1], w_full_addr[1:0]};

`ifdef APB4_AHB3_BRIDGE_TIMEOUT_EN
    localparam logic [1:0]  D_NONE  = 2'd0;
    localparam logic [1:0]  D_ADDR  = 2'd1;
    localparam logic [1:0]  D_DATA  = 2'd2;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_tcnt;
    logic [1:0]  r_drain;

    assign w_timeout      = ((r_state == S_ADDR) || (r_state == S_DATA)) && !ahb.HREADY
                            && (r_tcnt == TO_LAST);
    assign w_drain_busy   = (r_drain != D_NONE);
    assign w_drain_nonseq = (r_drain == D_ADDR);

    // After a timeout the APB side is released but the AHB transfer must still finish.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_tcnt  <= 16'd0;
            r_drain <= D_NONE;
        end else begin
            if (w_accept)
                r_tcnt <= 16'd0;
            else if (((r_state == S_ADDR) || (r_state == S_DATA)) && !ahb.HREADY)
                r_tcnt <= r_tcnt + 16'd1;

            case (r_drain)
                D_NONE:  if (w_timeout) r_drain <= (r_state == S_ADDR) ? D_ADDR : D_DATA;
                D_ADDR:  if (ahb.HREADY) r_drain <= D_DATA;
                D_DATA:  if (ahb.HREADY) r_drain <= D_NONE;
                default: r_drain <= D_NONE;
            endcase
        end
    end
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_drain_busy     = 1'b0;
    assign w_drain_nonseq   = 1'b0;
    assign w_unused_timeout = |16'(TIMEOUT_CYCLES);
`endif

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:
                if (w_accept)
                    w_state_next = (!apb.PWRITE || w_strb_legal) ? S_ADDR : S_RESP;
            S_ADDR:
                if (ahb.HREADY)
                    w_state_next = S_DATA;
                else if (w_timeout)
                    w_state_next = S_RESP;
            S_DATA:
                if (ahb.HREADY || w_timeout)
                    w_state_next = S_RESP;
            S_RESP:
                w_state_next = S_IDLE;
            default:
                w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ahb.HTRANS = HTRANS_IDLE;
        apb.PREADY = 1'b0;
        if ((r_state == S_ADDR) || w_drain_nonseq)
            ahb.HTRANS = HTRANS_NONSEQ;
        if (r_state == S_RESP)
            apb.PREADY = 1'b1;
    end

    // Reads always go out as aligned words; writes take lane/size from the strobe.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_haddr   <= 32'd0;
            r_hwdata  <= 32'd0;
            r_prdata  <= 32'd0;
            r_hsize   <= 3'd0;
            r_hprot   <= 4'd0;
            r_hwrite  <= 1'b0;
            r_pslverr <= 1'b0;
        end else begin
            if (w_accept) begin
                r_haddr   <= apb.PWRITE ? {w_full_addr[31:2], w_dec[4:3]}
                                        : {w_full_addr[31:2], 2'b00};
                r_hsize   <= apb.PWRITE ? w_dec[2:0] : 3'b010;
                r_hwrite  <= apb.PWRITE;
                r_hwdata  <= apb.PWDATA;
                r_hprot   <= {2'b00, apb.PPROT[0], ~apb.PPROT[2]};
                r_pslverr <= apb.PWRITE && !w_strb_legal && !w_strb_empty;
            end else if (w_timeout) begin
                r_pslverr <= 1'b1;
            end else if ((r_state == S_DATA) && ahb.HREADY) begin
                r_pslverr <= ahb.HRESP;
                if (!r_hwrite)
                    r_prdata <= ahb.HRDATA;
            end
        end
    end

    assign ahb.HSEL      = 1'b1;
    assign ahb.HBURST    = 3'b000;
    assign ahb.HMASTLOCK = 1'b0;
    assign ahb.HADDR     = r_haddr;
    assign ahb.HWDATA    = r_hwdata;
    assign ahb.HSIZE     = r_hsize;
    assign ahb.HWRITE    = r_hwrite;
    assign ahb.HPROT     = r_hprot;
    assign apb.PRDATA    = r_prdata;
    assign apb.PSLVERR   = r_pslverr;

endmodule

// File: tb/tb_apb4_ahb3lite_bridge.sv
// Directed self-checking bench for apb4_ahb3lite_bridge; the timeout scenario is
// compiled only when APB4_AHB3_BRIDGE_TIMEOUT_EN is defined.
module tb_apb4_ahb3lite_bridge;
    logic        clk = 1'b0;
    logic        rst_n;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] last_rd = 32'h0;

    apb4_if #(.PADDR_SIZE(16)) apb_bus ();
    ahb3lite_if ahb_bus ();

    apb4_ahb3lite_bridge #(
        .HADDR_BASE     (32'h2000_0000),
        .PADDR_SIZE     (16),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .CLK    (clk),
        .RESETn (rst_n),
        .apb    (apb_bus),
        .ahb    (ahb_bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apb_setup(input logic [15:0] addr, input logic wr, input logic [31:0] wdata,
                             input logic [3:0] strb, input logic [2:0] prot);
        apb_bus.PSEL    = 1'b1;
        apb_bus.PENABLE = 1'b0;
        apb_bus.PADDR   = addr;
        apb_bus.PWRITE  = wr;
        apb_bus.PWDATA  = wdata;
        apb_bus.PSTRB   = strb;
        apb_bus.PPROT   = prot;
    endtask

    task automatic apb_idle();
        apb_bus.PSEL    = 1'b0;
        apb_bus.PENABLE = 1'b0;
    endtask

    // Called at the negedge of setup cycle 0; returns at the negedge of the PREADY cycle.
    // The slave inserts ws wait states in the data phase (cycle 2 onward).
    task automatic apb_run(input int ws, input logic err, input logic [31:0] rdata, output int cyc,
                           output logic [1:0] h1, output logic [1:0] h2, output logic seen);
        cyc  = -1;
        h1   = 2'b11;
        h2   = 2'b11;
        seen = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            apb_bus.PENABLE = 1'b1;
            if (k == 1) h1 = ahb_bus.HTRANS;
            if (k == 2) h2 = ahb_bus.HTRANS;
            if (ahb_bus.HTRANS == 2'b10) seen = 1'b1;
            if (k >= 2) begin
                ahb_bus.HREADY = (k - 2 >= ws);
                ahb_bus.HRESP  = err && (k - 2 >= ws - 1);
                ahb_bus.HRDATA = (k - 2 >= ws) ? rdata : 32'h0BAD_0BAD;
            end
            if (apb_bus.PREADY === 1'b1) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        apb_idle();
        apb_bus.PADDR  = 16'h0;
        apb_bus.PWRITE = 1'b0;
        apb_bus.PWDATA = 32'h0;
        apb_bus.PSTRB  = 4'h0;
        apb_bus.PPROT  = 3'h0;
        ahb_bus.HREADY = 1'b1;
        ahb_bus.HRESP  = 1'b0;
        ahb_bus.HRDATA = 32'h0;
        repeat (2) @(negedge clk);
        n_vec++; if (ahb_bus.HTRANS !== 2'b00) begin n_err++; $display("FAIL reset_htrans: got %b want 00", ahb_bus.HTRANS); end
        n_vec++; if (ahb_bus.HADDR !== 32'h0) begin n_err++; $display("FAIL reset_haddr: got %h want 0", ahb_bus.HADDR); end
        n_vec++; if (ahb_bus.HWDATA !== 32'h0) begin n_err++; $display("FAIL reset_hwdata: got %h want 0", ahb_bus.HWDATA); end
        n_vec++; if ({ahb_bus.HSIZE, ahb_bus.HWRITE, ahb_bus.HPROT} !== 8'h00) begin n_err++; $display("FAIL reset_ctrl: got size=%b wr=%b prot=%b want 0", ahb_bus.HSIZE, ahb_bus.HWRITE, ahb_bus.HPROT); end
        n_vec++; if ({apb_bus.PREADY, apb_bus.PSLVERR} !== 2'b00) begin n_err++; $display("FAIL reset_apb_resp: got ready=%b err=%b want 0 0", apb_bus.PREADY, apb_bus.PSLVERR); end
        n_vec++; if (apb_bus.PRDATA !== 32'h0) begin n_err++; $display("FAIL reset_prdata: got %h want 0", apb_bus.PRDATA); end
        n_vec++; if ({ahb_bus.HSEL, ahb_bus.HBURST, ahb_bus.HMASTLOCK} !== 5'b1_000_0) begin n_err++; $display("FAIL reset_consts: got hsel=%b hburst=%b lock=%b want 1 000 0", ahb_bus.HSEL, ahb_bus.HBURST, ahb_bus.HMASTLOCK); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word_write();
        int cyc; logic [1:0] h1; logic [1:0] h2; logic seen;
        apb_setup(16'h0010, 1'b1, 32'hDEAD_BEEF, 4'b1111, 3'b001);
        apb_run(0, 1'b0, 32'h0, cyc, h1, h2, seen);
        n_vec++; if (cyc !== 3) begin n_err++; $display("FAIL wr_pready_cycle: got %0d want 3", cyc); end
        n_vec++; if (h1 !== 2'b10) begin n_err++; $display("FAIL wr_htrans_c1: got %b want 10", h1); end
        n_vec++; if (h2 !== 2'b00) begin n_err++; $display("FAIL wr_htrans_c2: got %b want 00", h2); end
        n_vec++; if (ahb_bus.HADDR !== 32'h2000_0010) begin n_err++; $display("FAIL wr_haddr: got %h want 20000010", ahb_bus.HADDR); end
        n_vec++; if ({ahb_bus.HSIZE, ahb_bus.HWRITE} !== 4'b010_1) begin n_err++; $display("FAIL wr_size_dir: got size=%b wr=%b want 010 1", ahb_bus.HSIZE, ahb_bus.HWRITE); end
        n_vec++; if (ahb_bus.HWDATA !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_hwdata: got %h want deadbeef", ahb_bus.HWDATA); end
        n_vec++; if (ahb_bus.HPROT !== 4'b0011) begin n_err++; $display("FAIL wr_hprot: got %b want 0011", ahb_bus.HPROT); end
        n_vec++; if (apb_bus.PSLVERR !== 1'b0) begin n_err++; $display("FAIL wr_pslverr: got %b want 0", apb_bus.PSLVERR); end
        apb_idle();
        @(negedge clk);
        n_vec++; if (apb_bus.PREADY !== 1'b0) begin n_err++; $display("FAIL wr_pready_one_cycle: got %b want 0", apb_bus.PREADY); end
    endtask

    task automatic test_read_waits();
        int cyc; logic [1:0] h1; logic [1:0] h2; logic seen;
        apb_setup(16'h0004, 1'b0, 32'hFFFF_FFFF, 4'b0110, 3'b100);
        apb_run(3, 1'b0, 32'h1234_5678, cyc, h1, h2, seen);
        n_vec++; if (cyc !== 6) begin n_err++; $display("FAIL rd_pready_cycle: got %0d want 6", cyc); end
        n_vec++; if (apb_bus.PRDATA !== 32'h1234_5678) begin n_err++; $display("FAIL rd_prdata: got %h want 12345678", apb_bus.PRDATA); end
        n_vec++; if (apb_bus.PSLVERR !== 1'b0) begin n_err++; $display("FAIL rd_pslverr: got %b want 0", apb_bus.PSLVERR); end
        n_vec++; if (ahb_bus.HADDR !== 32'h2000_0004) begin n_err++; $display("FAIL rd_haddr: got %h want 20000004", ahb_bus.HADDR); end
        n_vec++; if ({ahb_bus.HSIZE, ahb_bus.HWRITE, ahb_bus.HPROT} !== {3'b010, 1'b0, 4'b0000}) begin n_err++; $display("FAIL rd_ctrl: got size=%b wr=%b prot=%b want 010 0 0000", ahb_bus.HSIZE, ahb_bus.HWRITE, ahb_bus.HPROT); end
        last_rd = 32'h1234_5678;
        apb_idle();
        @(negedge clk);
    endtask

    task automatic test_strobes();
        int cyc; logic [1:0] h1; logic [1:0] h2; logic seen;
        logic [15:0] a; logic [3:0] s; logic [31:0] ea; logic [2:0] ez;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0:       begin a = 16'h0020; s = 4'b0100; ea = 32'h2000_0022; ez = 3'b000; end
                1:       begin a = 16'h0020; s = 4'b1100; ea = 32'h2000_0022; ez = 3'b001; end
                2:       begin a = 16'h0033; s = 4'b0010; ea = 32'h2000_0031; ez = 3'b000; end
                3:       begin a = 16'h0031; s = 4'b0011; ea = 32'h2000_0030; ez = 3'b001; end
                default: begin a = 16'h0040; s = 4'b1000; ea = 32'h2000_0043; ez = 3'b000; end
            endcase
            apb_setup(a, 1'b1, 32'h5555_0000 + i, s, 3'b000);
            apb_run(0, 1'b0, 32'h0, cyc, h1, h2, seen);
            n_vec++; if (ahb_bus.HADDR !== ea) begin n_err++; $display("FAIL strb%0d_haddr: got %h want %h", i, ahb_bus.HADDR, ea); end
            n_vec++; if (ahb_bus.HSIZE !== ez) begin n_err++; $display("FAIL strb%0d_hsize: got %b want %b", i, ahb_bus.HSIZE, ez); end
            n_vec++; if (cyc !== 3) begin n_err++; $display("FAIL strb%0d_cycle: got %0d want 3", i, cyc); end
            apb_idle();
            @(negedge clk);
        end
        n_vec++; if (apb_bus.PRDATA !== last_rd) begin n_err++; $display("FAIL prdata_hold_after_writes: got %h want %h", apb_bus.PRDATA, last_rd); end
    endtask

    task automatic test_illegal_strobe();
        int cyc; logic [1:0] h1; logic [1:0] h2; logic seen;
        apb_setup(16'h0050, 1'b1, 32'hAAAA_AAAA, 4'b0110, 3'b000);
        apb_run(0, 1'b0, 32'h0, cyc, h1, h2, seen);
        n_vec++; if (cyc !== 1) begin n_err++; $display("FAIL illegal_cycle: got %0d want 1", cyc); end
        n_vec++; if (apb_bus.PSLVERR !== 1'b1) begin n_err++; $display("FAIL illegal_pslverr: got %b want 1", apb_bus.PSLVERR); end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL illegal_no_ahb: got nonseq=%b want 0", seen); end
        apb_idle();
        @(negedge clk);
        n_vec++; if (ahb_bus.HTRANS !== 2'b00) begin n_err++; $display("FAIL illegal_htrans_after: got %b want 00", ahb_bus.HTRANS); end
        apb_setup(16'h0054, 1'b1, 32'hBBBB_BBBB, 4'b0000, 3'b000);
        apb_run(0, 1'b0, 32'h0, cyc, h1, h2, seen);
        n_vec++; if (cyc !== 1) begin n_err++; $display("FAIL empty_cycle: got %0d want 1", cyc); end
        n_vec++; if (apb_bus.PSLVERR !== 1'b0) begin n_err++; $display("FAIL empty_pslverr: got %b want 0", apb_bus.PSLVERR); end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL empty_no_ahb: got nonseq=%b want 0", seen); end
        apb_idle();
        @(negedge clk);
    endtask

    task automatic test_error_response();
        int cyc; logic [1:0] h1; logic [1:0] h2; logic seen;
        apb_setup(16'h0008, 1'b0, 32'h0, 4'b0000, 3'b000);
        apb_run(1, 1'b1, 32'hFFFF_0000, cyc, h1, h2, seen);
        n_vec++; if (cyc !== 4) begin n_err++; $display("FAIL err_cycle: got %0d want 4", cyc); end
        n_vec++; if (apb_bus.PSLVERR !== 1'b1) begin n_err++; $display("FAIL err_pslverr: got %b want 1", apb_bus.PSLVERR); end
        @(negedge clk);
        ahb_bus.HRESP = 1'b0;
        apb_setup(16'h000C, 1'b1, 32'h0000_C0DE, 4'b1111, 3'b000);
        apb_run(0, 1'b0, 32'h0, cyc, h1, h2, seen);
        n_vec++; if (cyc !== 3) begin n_err++; $display("FAIL after_err_cycle: got %0d want 3", cyc); end
        n_vec++; if (apb_bus.PSLVERR !== 1'b0) begin n_err++; $display("FAIL after_err_pslverr: got %b want 0", apb_bus.PSLVERR); end
        apb_idle();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc; logic [1:0] h1; logic [1:0] h2; logic seen;
        apb_setup(16'h0100, 1'b0, 32'h0, 4'b0000, 3'b000);
        apb_run(0, 1'b0, 32'hA5A5_0001, cyc, h1, h2, seen);
        n_vec++; if (cyc !== 3) begin n_err++; $display("FAIL b2b_first_cycle: got %0d want 3", cyc); end
        n_vec++; if (apb_bus.PRDATA !== 32'hA5A5_0001) begin n_err++; $display("FAIL b2b_first_prdata: got %h want a5a50001", apb_bus.PRDATA); end
        @(negedge clk);
        apb_setup(16'h0104, 1'b0, 32'h0, 4'b0000, 3'b000);
        apb_run(2, 1'b0, 32'h5A5A_0002, cyc, h1, h2, seen);
        n_vec++; if (cyc !== 5) begin n_err++; $display("FAIL b2b_second_cycle: got %0d want 5", cyc); end
        n_vec++; if (apb_bus.PRDATA !== 32'h5A5A_0002) begin n_err++; $display("FAIL b2b_second_prdata: got %h want 5a5a0002", apb_bus.PRDATA); end
        n_vec++; if (ahb_bus.HADDR !== 32'h2000_0104) begin n_err++; $display("FAIL b2b_second_haddr: got %h want 20000104", ahb_bus.HADDR); end
        last_rd = 32'h5A5A_0002;
        apb_idle();
        @(negedge clk);
    endtask

    task automatic test_reset_inflight();
        logic bad;
        apb_setup(16'h0060, 1'b1, 32'hCAFE_F00D, 4'b1111, 3'b000);
        ahb_bus.HREADY = 1'b1;
        @(negedge clk);
        apb_bus.PENABLE = 1'b1;
        ahb_bus.HREADY  = 1'b0;
        @(negedge clk);
        n_vec++; if (ahb_bus.HTRANS !== 2'b10) begin n_err++; $display("FAIL rst_addr_pre_htrans: got %b want 10", ahb_bus.HTRANS); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (ahb_bus.HTRANS !== 2'b00) begin n_err++; $display("FAIL rst_addr_htrans: got %b want 00", ahb_bus.HTRANS); end
        n_vec++; if (ahb_bus.HADDR !== 32'h0) begin n_err++; $display("FAIL rst_addr_haddr: got %h want 0", ahb_bus.HADDR); end
        apb_idle();
        ahb_bus.HREADY = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        apb_setup(16'h0064, 1'b1, 32'h1357_9BDF, 4'b1111, 3'b000);
        @(negedge clk);
        apb_bus.PENABLE = 1'b1;
        @(negedge clk);
        ahb_bus.HREADY = 1'b0;
        n_vec++; if (ahb_bus.HWDATA !== 32'h1357_9BDF) begin n_err++; $display("FAIL rst_data_pre_hwdata: got %h want 13579bdf", ahb_bus.HWDATA); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if ({ahb_bus.HTRANS, apb_bus.PREADY} !== 3'b00_0) begin n_err++; $display("FAIL rst_data_resp: got htrans=%b pready=%b want 00 0", ahb_bus.HTRANS, apb_bus.PREADY); end
        n_vec++; if (ahb_bus.HWDATA !== 32'h0) begin n_err++; $display("FAIL rst_data_hwdata: got %h want 0", ahb_bus.HWDATA); end
        apb_idle();
        ahb_bus.HREADY = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (apb_bus.PREADY !== 1'b0) bad = 1'b1;
        end
        n_vec++; if (bad !== 1'b0) begin n_err++; $display("FAIL rst_no_pready: got pready seen=%b want 0", bad); end
        last_rd = 32'h0;
    endtask

`ifdef APB4_AHB3_BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        int cyc; logic stalled;
        apb_setup(16'h0200, 1'b0, 32'h0, 4'b0000, 3'b000);
        apb_run(0, 1'b0, 32'h7777_0001, cyc, , , );
        last_rd = 32'h7777_0001;
        apb_idle();
        @(negedge clk);
        ahb_bus.HREADY = 1'b0;
        apb_setup(16'h0070, 1'b0, 32'h0, 4'b0000, 3'b000);
        cyc = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            apb_bus.PENABLE = 1'b1;
            if (apb_bus.PREADY === 1'b1) begin cyc = k; break; end
        end
        n_vec++; if (cyc !== 9) begin n_err++; $display("FAIL to_cycle: got %0d want 9", cyc); end
        n_vec++; if (apb_bus.PSLVERR !== 1'b1) begin n_err++; $display("FAIL to_pslverr: got %b want 1", apb_bus.PSLVERR); end
        n_vec++; if (apb_bus.PRDATA !== last_rd) begin n_err++; $display("FAIL to_prdata: got %h want %h", apb_bus.PRDATA, last_rd); end
        n_vec++; if (ahb_bus.HTRANS !== 2'b10) begin n_err++; $display("FAIL to_drain_nonseq: got %b want 10", ahb_bus.HTRANS); end
        apb_idle();
        @(negedge clk);
        apb_setup(16'h0074, 1'b1, 32'h0F0F_0F0F, 4'b1111, 3'b000);
        stalled = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            apb_bus.PENABLE = 1'b1;
            if (apb_bus.PREADY !== 1'b0) stalled = 1'b1;
        end
        n_vec++; if (stalled !== 1'b0) begin n_err++; $display("FAIL to_stall_pready: got seen=%b want 0", stalled); end
        ahb_bus.HREADY = 1'b1;
        cyc = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (apb_bus.PREADY === 1'b1) begin cyc = k; break; end
        end
        n_vec++; if (cyc !== 5) begin n_err++; $display("FAIL to_drain_cycle: got %0d want 5", cyc); end
        n_vec++; if (apb_bus.PSLVERR !== 1'b0) begin n_err++; $display("FAIL to_second_pslverr: got %b want 0", apb_bus.PSLVERR); end
        n_vec++; if (ahb_bus.HADDR !== 32'h2000_0074) begin n_err++; $display("FAIL to_second_haddr: got %h want 20000074", ahb_bus.HADDR); end
        apb_idle();
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_word_write();
        test_read_waits();
        test_strobes();
        test_illegal_strobe();
        test_error_response();
        test_back_to_back();
        test_reset_inflight();
`ifdef APB4_AHB3_BRIDGE_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
